// File: rtl/usb_tx_encoder.sv
// -----------------------------------------------------------------------------
// usb_tx_encoder
//   USB full-speed transmit encoder. Takes packet bytes from the packet/CRC
//   generator, serialises them LSB-first behind an (optionally generated)
//   SYNC field, inserts stuff bits after six consecutive ones, NRZI-encodes
//   the stream and finishes every packet with an EOP (SE0, SE0, J).
//
//   Optional feature macro: USB_TX_SYNC_GEN_EN
//     defined   : the encoder emits SYNC (0x80) itself in a dedicated state.
//     undefined : no SYNC state; the caller sends 0x80 as byte 0 and the first
//                 accepted byte is driven on the line at the accepting edge.
//
//   Ports
//     clk       system clock
//     n_rst     synchronous active-low reset
//     tx_data   byte to send, bit 0 goes on the bus first
//     tx_valid  tx_data/tx_last are valid
//     tx_last   accepted byte is the final byte of the packet
//     tx_ready  encoder can accept a byte this cycle
//     d_plus    bus D+ (registered)
//     d_minus   bus D- (registered)
//     tx_busy   high while a packet is in flight (state != IDLE)
//     tx_done   one-cycle pulse on normal packet completion
//     tx_err    one-cycle pulse when a packet is aborted by underrun
//
//   Handshake: a byte is transferred on every rising clk edge where
//   tx_valid && tx_ready. tx_ready depends only on registered state, never on
//   tx_valid; the source holds tx_data/tx_last stable while tx_valid is high
//   and tx_ready is low.
//
//   The FSM state is kept in the enum signal "state" for hierarchical probing.
// -----------------------------------------------------------------------------
module usb_tx_encoder #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       d_plus,
  output logic       d_minus,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err
);

`ifdef USB_TX_SYNC_GEN_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_SYNC = 3'd1, S_DATA = 3'd2, S_EOP_SE0 = 3'd3, S_EOP_J = 3'd4
  } state_t;
  localparam logic [7:0] SYNC_BYTE = 8'h80;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_DATA = 3'd2, S_EOP_SE0 = 3'd3, S_EOP_J = 3'd4
  } state_t;
`endif

  localparam logic [7:0] BIT_LAST = 8'(CLKS_PER_BIT - 1);

  state_t     state, state_n;
  logic [7:0] bit_cnt, bit_cnt_n;
  logic [7:0] shreg, shreg_n;        // data bits still to go, bit 0 next
  logic [3:0] bits_left, bits_left_n;
  logic [2:0] ones_cnt, ones_cnt_n;  // consecutive ones on the wire, incl. current bit
  logic [7:0] buf_data, buf_data_n;
  logic       buf_full, buf_full_n;
  logic       last_seen, last_seen_n;
  logic       aborted, aborted_n;
  logic       se0_second, se0_second_n;
  logic       d_plus_n, d_minus_n, tx_done_n, tx_err_n;

  logic       bit_strobe, accept;
  logic       launch, launch_fresh;
  logic [7:0] launch_src;

  assign bit_strobe = (state != S_IDLE) && (bit_cnt == BIT_LAST);
  assign tx_ready   = !buf_full && !last_seen && (state != S_EOP_SE0) && (state != S_EOP_J);
  assign accept     = tx_valid && tx_ready;
  assign tx_busy    = (state != S_IDLE);

  always_comb begin
    state_n      = state;
    bit_cnt_n    = bit_cnt;
    shreg_n      = shreg;
    bits_left_n  = bits_left;
    ones_cnt_n   = ones_cnt;
    buf_data_n   = buf_data;
    buf_full_n   = buf_full;
    last_seen_n  = last_seen;
    aborted_n    = aborted;
    se0_second_n = se0_second;
    d_plus_n     = d_plus;
    d_minus_n    = d_minus;
    tx_done_n    = 1'b0;
    tx_err_n     = 1'b0;
    launch       = 1'b0;
    launch_fresh = 1'b0;
    launch_src   = shreg;

    if (state != S_IDLE) bit_cnt_n = bit_strobe ? 8'd0 : bit_cnt + 8'd1;

    if (accept) begin
      buf_data_n = tx_data;
      buf_full_n = 1'b1;
      if (tx_last) last_seen_n = 1'b1;
    end

    case (state)
      S_IDLE: begin
        if (accept) begin
          // First symbol goes out on this very edge; the timer restarts here.
          bit_cnt_n    = 8'd0;
          launch       = 1'b1;
          launch_fresh = 1'b1;
`ifdef USB_TX_SYNC_GEN_EN
          state_n      = S_SYNC;
          launch_src   = SYNC_BYTE;
`else
          state_n      = S_DATA;
          launch_src   = tx_data;
          buf_full_n   = 1'b0;
`endif
        end
      end
`ifdef USB_TX_SYNC_GEN_EN
      S_SYNC,
`endif
      S_DATA: begin
        if (bit_strobe) begin
          if (ones_cnt == 3'd6) begin
            // Stuffed zero: toggle without consuming a data bit.
            d_plus_n   = ~d_plus;
            d_minus_n  = ~d_minus;
            ones_cnt_n = 3'd0;
          end else if (bits_left != 4'd0) begin
            launch = 1'b1;
          end else if (buf_full) begin
            launch       = 1'b1;
            launch_fresh = 1'b1;
            launch_src   = buf_data;
            buf_full_n   = 1'b0;
            state_n      = S_DATA;
          end else if (accept) begin
            // Byte arriving on the exact edge it is needed: pass it straight
            // through rather than calling it an underrun.
            launch       = 1'b1;
            launch_fresh = 1'b1;
            launch_src   = tx_data;
            buf_full_n   = 1'b0;
          end else begin
            state_n      = S_EOP_SE0;
            d_plus_n     = 1'b0;
            d_minus_n    = 1'b0;
            se0_second_n = 1'b0;
            if (!last_seen) begin
              tx_err_n  = 1'b1;
              aborted_n = 1'b1;
            end
          end
        end
      end
      S_EOP_SE0: begin
        if (bit_strobe) begin
          if (se0_second) begin
            state_n   = S_EOP_J;
            d_plus_n  = 1'b1;
            d_minus_n = 1'b0;
          end else begin
            se0_second_n = 1'b1;
          end
        end
      end
      S_EOP_J: begin
        if (bit_strobe) begin
          state_n      = S_IDLE;
          tx_done_n    = !aborted;
          last_seen_n  = 1'b0;
          aborted_n    = 1'b0;
          ones_cnt_n   = 3'd0;
          se0_second_n = 1'b0;
          buf_full_n   = 1'b0;
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Put bit 0 of launch_src on the wire: NRZI toggles on 0, holds on 1.
    if (launch) begin
      shreg_n     = {1'b0, launch_src[7:1]};
      bits_left_n = launch_fresh ? 4'd7 : bits_left - 4'd1;
      if (launch_src[0]) begin
        ones_cnt_n = ones_cnt + 3'd1;
      end else begin
        ones_cnt_n = 3'd0;
        d_plus_n   = ~d_plus;
        d_minus_n  = ~d_minus;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state      <= S_IDLE;
      bit_cnt    <= 8'd0;
      shreg      <= 8'd0;
      bits_left  <= 4'd0;
      ones_cnt   <= 3'd0;
      buf_data   <= 8'd0;
      buf_full   <= 1'b0;
      last_seen  <= 1'b0;
      aborted    <= 1'b0;
      se0_second <= 1'b0;
      d_plus     <= 1'b1;
      d_minus    <= 1'b0;
      tx_done    <= 1'b0;
      tx_err     <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      shreg      <= shreg_n;
      bits_left  <= bits_left_n;
      ones_cnt   <= ones_cnt_n;
      buf_data   <= buf_data_n;
      buf_full   <= buf_full_n;
      last_seen  <= last_seen_n;
      aborted    <= aborted_n;
      se0_second <= se0_second_n;
      d_plus     <= d_plus_n;
      d_minus    <= d_minus_n;
      tx_done    <= tx_done_n;
      tx_err     <= tx_err_n;
    end
  end

endmodule
